// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the cache-to-memory arbiter.
package cache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  // Number of byte-offset bits inside one cache line.
  function automatic int unsigned line_off_bits(input int unsigned beats,
                                                input int unsigned data_w);
    return $clog2(beats * data_w / 8);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the caller owns the last-grant register.
module rr_arbiter2
  import cache_mem_pkg::*;
(
  input  logic       req_ic_i,
  input  logic       req_dc_i,
  input  owner_e     last_grant_i,
  output logic [1:0] grant_c_o
);

  // One-hot grant (bit 0 icache, bit 1 dcache); a tie goes to the requester not granted last
  always_comb begin
    grant_c_o = 2'b00;
    if (req_ic_i && req_dc_i) begin
      grant_c_o = (last_grant_i == OWN_IC) ? 2'b10 : 2'b01;
    end else if (req_ic_i) begin
      grant_c_o = 2'b01;
    end else if (req_dc_i) begin
      grant_c_o = 2'b10;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the off-chip memory port between icache fills and dcache fills/write-backs.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     ic_req,
  input  logic [ADDR_W-1:0]        ic_addr,
  output logic                     ic_done,
  input  logic                     dc_req,
  input  logic                     dc_we,
  input  logic [ADDR_W-1:0]        dc_addr,
  input  logic [DATA_W-1:0]        dc_wdata,
  output logic [$clog2(BEATS)-1:0] dc_wbeat,
  output logic                     dc_done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ic_rvalid,
  output logic                     dc_rvalid,
  output logic                     mem_cmd_valid,
  input  logic                     mem_cmd_ready,
  output logic                     mem_cmd_rnw,
  output logic [ADDR_W-1:0]        mem_cmd_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rdata_valid,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_wdata_valid,
  input  logic                     mem_wdata_ready,
  output logic                     busy
);

  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned OFF_W = line_off_bits(BEATS, DATA_W);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_q, last_d;
  logic                rnw_q, rnw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ic_done_q, ic_done_d;
  logic                dc_done_q, dc_done_d;
  logic [1:0]          grant;

  // A requester whose done is pulsing this cycle is finishing, not asking again
  rr_arbiter2 u_arb (
    .req_ic_i     (ic_req && !ic_done_q),
    .req_dc_i     (dc_req && !dc_done_q),
    .last_grant_i (last_q),
    .grant_c_o    (grant)
  );

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transfer context, beat counter and done pulses
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      owner_q   <= OWN_IC;
      last_q    <= OWN_IC;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      ic_done_q <= ic_done_d;
      dc_done_q <= dc_done_d;
    end
  end

  // Next state: grant in IDLE, command handshake, then count BEATS data beats
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rnw_d     = rnw_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    ic_done_d = 1'b0;
    dc_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          owner_d = grant[1] ? OWN_DC : OWN_IC;
          last_d  = grant[1] ? OWN_DC : OWN_IC;
          rnw_d   = grant[1] ? ~dc_we : 1'b1;
          addr_d  = (grant[1] ? dc_addr : ic_addr) & LINE_MASK;
          state_d = CMD;
        end
      end
      CMD: begin
        if (mem_cmd_ready) begin
          cnt_d   = '0;
          state_d = rnw_q ? RDATA : WDATA;
        end
      end
      RDATA: begin
        if (mem_rdata_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d   = IDLE;
            ic_done_d = (owner_q == OWN_IC);
            dc_done_d = (owner_q == OWN_DC);
          end
        end
      end
      WDATA: begin
        if (mem_wdata_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d   = IDLE;
            dc_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; read/write beats pass through with no added latency
  always_comb begin
    mem_cmd_valid   = 1'b0;
    mem_cmd_rnw     = 1'b0;
    mem_cmd_addr    = '0;
    rdata           = '0;
    ic_rvalid       = 1'b0;
    dc_rvalid       = 1'b0;
    mem_wdata       = '0;
    mem_wdata_valid = 1'b0;
    dc_wbeat        = '0;
    case (state_q)
      CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_rnw   = rnw_q;
        mem_cmd_addr  = addr_q;
      end
      RDATA: begin
        rdata     = mem_rdata;
        ic_rvalid = mem_rdata_valid && (owner_q == OWN_IC);
        dc_rvalid = mem_rdata_valid && (owner_q == OWN_DC);
      end
      WDATA: begin
        mem_wdata_valid = 1'b1;
        mem_wdata       = dc_wdata;
        dc_wbeat        = cnt_q;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign ic_done = ic_done_q;
  assign dc_done = dc_done_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter against a transaction-level model.
module tb_cache_mem_arbiter;

  localparam int unsigned BEATS      = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_BYTES = BEATS * DATA_W / 8;

  logic              CLK = 1'b0;
  logic              reset = 1'b0;
  logic              ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
  logic [ADDR_W-1:0] ic_addr = '0, dc_addr = '0;
  logic [DATA_W-1:0] dc_wdata;
  logic [1:0]        dc_wbeat;
  logic              ic_done, dc_done, ic_rvalid, dc_rvalid, busy;
  logic [DATA_W-1:0] rdata, mem_wdata;
  logic              mem_cmd_valid, mem_cmd_rnw, mem_wdata_valid;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic              mem_cmd_ready = 1'b0, mem_rdata_valid = 1'b0, mem_wdata_ready = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;

  // requester / memory knobs
  logic              ic_want = 1'b0, dc_want = 1'b0, dc_wev = 1'b0;
  logic [31:0]       ic_av = '0, dc_av = '0, wbase = '0;
  int unsigned       cmd_pct = 100, rv_pct = 100, wr_pct = 100;
  bit                rd_seq = 1'b0, wr_toggle = 1'b0;

  // transaction-level model
  bit                busy_m, cmd_done_m, rnw_m;
  int                own_m, beat_m, wr_cyc, last_m, done_pend;
  logic [31:0]       addr_m;
  logic [31:0]       ic_got[$], dc_got[$];
  int                order[$];
  int                wr_acc, cmd_cycles;

  int                n_checks = 0;
  int                n_fail = 0;

  assign dc_wdata = wbase + 32'h11 * 32'(dc_wbeat);

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.BEATS(BEATS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK             (CLK),
    .reset           (reset),
    .ic_req          (ic_req),
    .ic_addr         (ic_addr),
    .ic_done         (ic_done),
    .dc_req          (dc_req),
    .dc_we           (dc_we),
    .dc_addr         (dc_addr),
    .dc_wdata        (dc_wdata),
    .dc_wbeat        (dc_wbeat),
    .dc_done         (dc_done),
    .rdata           (rdata),
    .ic_rvalid       (ic_rvalid),
    .dc_rvalid       (dc_rvalid),
    .mem_cmd_valid   (mem_cmd_valid),
    .mem_cmd_ready   (mem_cmd_ready),
    .mem_cmd_rnw     (mem_cmd_rnw),
    .mem_cmd_addr    (mem_cmd_addr),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_wdata       (mem_wdata),
    .mem_wdata_valid (mem_wdata_valid),
    .mem_wdata_ready (mem_wdata_ready),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic pick(input int unsigned pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  task automatic model_reset();
    busy_m = 1'b0; cmd_done_m = 1'b0; rnw_m = 1'b0;
    own_m = 0; beat_m = 0; wr_cyc = 0; last_m = 0; done_pend = 0;
  endtask

  task automatic reset_checks();
    chk("rst_busy", busy, 0);
    chk("rst_ic_done", ic_done, 0);
    chk("rst_dc_done", dc_done, 0);
    chk("rst_cmd_valid", mem_cmd_valid, 0);
    chk("rst_cmd_rnw", mem_cmd_rnw, 0);
    chk("rst_cmd_addr", mem_cmd_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ic_rvalid", ic_rvalid, 0);
    chk("rst_dc_rvalid", dc_rvalid, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wdata_valid", mem_wdata_valid, 0);
    chk("rst_wbeat", dc_wbeat, 0);
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  task automatic check_cycle();
    int done_now;
    bit r_ic, r_dc;
    int win;
    if (!reset) begin
      reset_checks();
      model_reset();
      return;
    end
    done_now  = done_pend;
    done_pend = 0;
    chk("ic_done", ic_done, 64'(done_now == 1));
    chk("dc_done", dc_done, 64'(done_now == 2));
    if (done_now == 1) ic_want = 1'b0;
    if (done_now == 2) dc_want = 1'b0;
    if (mem_cmd_valid) cmd_cycles++;
    if (!busy_m) begin
      chk("idle_busy", busy, 0);
      chk("idle_cmd_valid", mem_cmd_valid, 0);
      chk("idle_ic_rvalid", ic_rvalid, 0);
      chk("idle_dc_rvalid", dc_rvalid, 0);
      chk("idle_wdata_valid", mem_wdata_valid, 0);
      r_ic = ic_req && (done_now != 1);
      r_dc = dc_req && (done_now != 2);
      if (r_ic || r_dc) begin
        win = (r_ic && r_dc) ? (1 - last_m) : (r_dc ? 1 : 0);
        busy_m = 1'b1; cmd_done_m = 1'b0; own_m = win; last_m = win;
        order.push_back(win);
        rnw_m  = (win == 1) ? !dc_we : 1'b1;
        addr_m = (win == 1) ? dc_addr : ic_addr;
      end
    end else if (!cmd_done_m) begin
      chk("cmd_busy", busy, 1);
      chk("cmd_valid", mem_cmd_valid, 1);
      chk("cmd_rnw", mem_cmd_rnw, rnw_m);
      chk("cmd_addr", mem_cmd_addr, (addr_m / LINE_BYTES) * LINE_BYTES);
      chk("cmd_ic_rvalid", ic_rvalid, 0);
      chk("cmd_dc_rvalid", dc_rvalid, 0);
      chk("cmd_wdata_valid", mem_wdata_valid, 0);
      if (mem_cmd_ready) begin
        cmd_done_m = 1'b1; beat_m = 0; wr_cyc = 0;
      end
    end else if (rnw_m) begin
      chk("rd_busy", busy, 1);
      chk("rd_cmd_valid", mem_cmd_valid, 0);
      chk("rd_wdata_valid", mem_wdata_valid, 0);
      chk("rd_ic_rvalid", ic_rvalid, 64'(mem_rdata_valid && own_m == 0));
      chk("rd_dc_rvalid", dc_rvalid, 64'(mem_rdata_valid && own_m == 1));
      chk("rd_rdata", rdata, mem_rdata);
      if (mem_rdata_valid) begin
        if (own_m == 0) ic_got.push_back(mem_rdata);
        else            dc_got.push_back(mem_rdata);
        beat_m++;
        if (beat_m == BEATS) begin
          busy_m = 1'b0; done_pend = own_m + 1;
        end
      end
    end else begin
      chk("wr_busy", busy, 1);
      chk("wr_cmd_valid", mem_cmd_valid, 0);
      chk("wr_ic_rvalid", ic_rvalid, 0);
      chk("wr_dc_rvalid", dc_rvalid, 0);
      chk("wr_wdata_valid", mem_wdata_valid, 1);
      chk("wr_wbeat", dc_wbeat, beat_m);
      chk("wr_wdata", mem_wdata, wbase + 32'h11 * 32'(beat_m));
      wr_cyc++;
      if (mem_wdata_ready) begin
        wr_acc++;
        beat_m++;
        if (beat_m == BEATS) begin
          busy_m = 1'b0; done_pend = 2;
        end
      end
    end
  endtask

  // One clock: drive inputs after the falling edge, check 1 ns later
  task automatic cycle();
    @(negedge CLK);
    ic_req          = ic_want;
    ic_addr         = ic_av;
    dc_req          = dc_want;
    dc_we           = dc_wev;
    dc_addr         = dc_av;
    mem_cmd_ready   = pick(cmd_pct);
    mem_rdata_valid = pick(rv_pct);
    mem_rdata       = rd_seq ? (32'hA0 + 32'(beat_m)) : $urandom;
    mem_wdata_ready = wr_toggle ? ((wr_cyc % 2) == 0) : pick(wr_pct);
    #1;
    check_cycle();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((ic_want || dc_want) && n < budget) begin
      cycle();
      n++;
    end
    chk("timeout", 64'(ic_want || dc_want), 0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) cycle();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset(3);

    // Single icache fill, memory always ready
    rd_seq = 1'b1; cmd_pct = 100; rv_pct = 100;
    ic_got.delete(); dc_got.delete();
    ic_av = 32'h0000_1234; ic_want = 1'b1;
    wait_idle(30);
    chk("ic_fill_beats", ic_got.size(), BEATS);
    for (int i = 0; i < ic_got.size(); i++) chk("ic_fill_data", ic_got[i], 32'hA0 + 32'(i));
    chk("ic_fill_no_dc", dc_got.size(), 0);
    rd_seq = 1'b0;

    // Dcache write-back with alternating write-ready
    wr_toggle = 1'b1; wr_acc = 0; wbase = 32'h0;
    dc_av = 32'h1000_0008; dc_wev = 1'b1; dc_want = 1'b1;
    wait_idle(40);
    chk("wb_accepts", wr_acc, BEATS);
    wr_toggle = 1'b0;

    // Simultaneous requests straight out of reset, twice
    do_reset(2);
    order.delete();
    ic_av = 32'h0000_0300; dc_av = 32'h0000_0404; dc_wev = 1'b0;
    ic_want = 1'b1; dc_want = 1'b1;
    wait_idle(60);
    ic_want = 1'b1; dc_want = 1'b1;
    wait_idle(60);
    chk("tie_count", order.size(), 4);
    if (order.size() == 4) begin
      chk("tie0_dc", order[0], 1);
      chk("tie1_ic", order[1], 0);
      chk("tie2_dc", order[2], 1);
      chk("tie3_ic", order[3], 0);
    end

    // Command stalled for 10 cycles with stray read-valids
    ic_got.delete();
    cmd_pct = 0; rv_pct = 50; cmd_cycles = 0;
    ic_av = 32'h0000_5678; ic_want = 1'b1;
    repeat (11) cycle();
    chk("cmd_hold_cycles", cmd_cycles, 10);
    chk("cmd_hold_no_beats", ic_got.size(), 0);
    cmd_pct = 100; rv_pct = 100;
    wait_idle(30);

    // Asynchronous reset during read beat 2, then a clean fill
    ic_av = 32'h0000_0abc; ic_want = 1'b1;
    for (int n = 0; n < 20 && !(busy_m && cmd_done_m && rnw_m && beat_m == 2); n++) cycle();
    chk("reached_beat2", 64'(busy_m && cmd_done_m && beat_m == 2), 1);
    #1;
    reset = 1'b0;
    #1;
    reset_checks();
    model_reset();
    ic_want = 1'b0;
    do_reset(2);
    ic_got.delete();
    ic_av = 32'h2000_0040; ic_want = 1'b1;
    wait_idle(30);
    chk("post_reset_beats", ic_got.size(), BEATS);

    // Randomized traffic
    cmd_pct = 60; rv_pct = 60; wr_pct = 60;
    for (int i = 0; i < 600; i++) begin
      if (!ic_want && $urandom_range(3, 0) == 0) begin
        ic_want = 1'b1; ic_av = $urandom;
      end
      if (!dc_want && $urandom_range(3, 0) == 0) begin
        dc_want = 1'b1; dc_wev = 1'($urandom_range(1, 0)); dc_av = $urandom; wbase = $urandom;
      end
      cycle();
    end
    wait_idle(300);
    cycle();
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
